// File: rtl/qpsk_mapper.sv
// qpsk_mapper: pairs a serial interleaved bit stream into QPSK constellation
// points and queues them in a small output FIFO towards the IFFT stage.
// Every Ncbps/Ncpc-th symbol is tagged as the last of its OFDM block.
// Optional build macro QPSK_SYM_INDEX_EN adds the sym_index output, which is
// the in-block index of the head symbol.

module qpsk_mapper #(
   parameter int unsigned Ncbps      = 192,
   parameter int unsigned Ncpc       = 2,
   parameter int unsigned DW         = 16,
   parameter int unsigned AMP        = 23170,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic signed [DW-1:0] I_out,
   output logic signed [DW-1:0] Q_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 last_out
`ifdef QPSK_SYM_INDEX_EN
   ,
   output logic [6:0]           sym_index
`endif
);

   localparam int unsigned SymPerBlk = Ncbps / Ncpc;
   localparam int unsigned CntW      = (SymPerBlk > 1) ? $clog2(SymPerBlk) : 1;
   localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);

   localparam logic [CntW-1:0]        CntMax = CntW'(SymPerBlk - 1);
   localparam logic signed [DW-1:0]   AmpPos = DW'(AMP);
   localparam logic signed [DW-1:0]   AmpNeg = -AmpPos;

   typedef enum logic [0:0] {
      StB0,
      StB1
   } pair_state_e;

   // ----------------------------------------------------------------------
   // Declarations
   // ----------------------------------------------------------------------
   pair_state_e state_q, state_d;

   logic                 reset_q;
   logic                 b0_q;
   logic [CntW-1:0]      cnt_q;

   logic [PtrW:0]        wr_ptr_q;
   logic [PtrW:0]        rd_ptr_q;
   logic [PtrW-1:0]      wr_idx;
   logic [PtrW-1:0]      rd_idx;

   logic signed [DW-1:0] mem_i    [FIFO_DEPTH];
   logic signed [DW-1:0] mem_q    [FIFO_DEPTH];
   logic                 mem_last [FIFO_DEPTH];

   logic signed [DW-1:0] hold_i_q;
   logic signed [DW-1:0] hold_q_q;
   logic                 hold_last_q;

`ifdef QPSK_SYM_INDEX_EN
   logic [CntW-1:0]      mem_idx  [FIFO_DEPTH];
   logic [CntW-1:0]      hold_idx_q;
`endif

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 accept;
   logic                 latch_b0;
   logic                 push;
   logic                 pop;

   logic signed [DW-1:0] sym_i;
   logic signed [DW-1:0] sym_q;
   logic                 sym_last;

   // ----------------------------------------------------------------------
   // Handshake and FIFO status
   // ----------------------------------------------------------------------
   // Registered copy of reset keeps ready_out low for one cycle after reset.
   always_ff @(posedge clk) begin
      reset_q <= reset;
   end

   // Pointers carry one extra wrap bit to tell full from empty.
   always_comb begin
      wr_idx     = wr_ptr_q[PtrW-1:0];
      rd_idx     = rd_ptr_q[PtrW-1:0];
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
   end

   // Ready depends only on registered state, never on valid_in or ready_in.
   always_comb begin
      ready_out = !reset_q && !fifo_full;
      accept    = valid_in && ready_out;
      valid_out = !fifo_empty;
      pop       = valid_out && ready_in;
   end

   // ----------------------------------------------------------------------
   // Pair FSM
   // ----------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StB0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: advance one half of the pair on every accepted bit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StB0:    if (accept) state_d = StB1;
         StB1:    if (accept) state_d = StB0;
         default: state_d = StB0;
      endcase
   end

   // FSM outputs: latch the first bit, push the symbol on the second.
   always_comb begin
      latch_b0 = 1'b0;
      push     = 1'b0;
      unique case (state_q)
         StB0:    latch_b0 = accept;
         StB1:    push     = accept;
         default: ;
      endcase
   end

   // First bit of the pair, feeds the in-phase component.
   always_ff @(posedge clk) begin
      if (reset) begin
         b0_q <= 1'b0;
      end else if (latch_b0) begin
         b0_q <= data_in;
      end
   end

   // ----------------------------------------------------------------------
   // Constellation mapping and block position
   // ----------------------------------------------------------------------
   // Gray QPSK: bit 0 maps to +AMP, bit 1 to -AMP on each axis.
   always_comb begin
      sym_i    = b0_q    ? AmpNeg : AmpPos;
      sym_q    = data_in ? AmpNeg : AmpPos;
      sym_last = (cnt_q == CntMax);
   end

   // Symbol counter within the OFDM block, wraps after the last symbol.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (push) begin
         if (cnt_q == CntMax) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   // ----------------------------------------------------------------------
   // Output FIFO
   // ----------------------------------------------------------------------
   // Storage; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_i[wr_idx]    <= sym_i;
         mem_q[wr_idx]    <= sym_q;
         mem_last[wr_idx] <= sym_last;
`ifdef QPSK_SYM_INDEX_EN
         mem_idx[wr_idx]  <= cnt_q;
`endif
      end
   end

   // Pointers; push and pop in the same cycle are both honoured.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
         end
      end
   end

   // Copy of the most recently popped head, shown while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_i_q    <= '0;
         hold_q_q    <= '0;
         hold_last_q <= 1'b0;
`ifdef QPSK_SYM_INDEX_EN
         hold_idx_q  <= '0;
`endif
      end else if (pop) begin
         hold_i_q    <= mem_i[rd_idx];
         hold_q_q    <= mem_q[rd_idx];
         hold_last_q <= mem_last[rd_idx];
`ifdef QPSK_SYM_INDEX_EN
         hold_idx_q  <= mem_idx[rd_idx];
`endif
      end
   end

   // Head of FIFO drives the outputs; empty FIFO keeps the last values.
   always_comb begin
      if (fifo_empty) begin
         I_out    = hold_i_q;
         Q_out    = hold_q_q;
         last_out = hold_last_q;
      end else begin
         I_out    = mem_i[rd_idx];
         Q_out    = mem_q[rd_idx];
         last_out = mem_last[rd_idx];
      end
   end

`ifdef QPSK_SYM_INDEX_EN
   // In-block index travels with the head exactly like I/Q.
   always_comb begin
      if (fifo_empty) begin
         sym_index = 7'(hold_idx_q);
      end else begin
         sym_index = 7'(mem_idx[rd_idx]);
      end
   end
`endif

   // ----------------------------------------------------------------------
   // Sanity properties
   // ----------------------------------------------------------------------
   push_not_full_a : assert property (@(posedge clk) disable iff (reset)
      push |-> !fifo_full);
   pop_not_empty_a : assert property (@(posedge clk) disable iff (reset)
      pop |-> !fifo_empty);

endmodule
